// File: rtl/miner_pkg.sv
// Shared types and widths for the nonce-search scheduler and its SHA datapath.
package miner_pkg;
  localparam int MSG_W    = 440;
  localparam int DIGEST_W = 256;
  localparam int NONCE_W  = 32;
  localparam int HEADER_W = MSG_W - NONCE_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_CHECK, S_FINISH
  } state_e;
endpackage

// File: rtl/sha_nonce_scheduler_if.sv
// Control, status and SHA-side signals of the nonce scheduler, bundled.
interface sha_nonce_scheduler_if;
  import miner_pkg::*;

  logic                start;
  logic                abort;
  logic [HEADER_W-1:0] header_prefix;
  logic [NONCE_W-1:0]  nonce_start;
  logic [NONCE_W-1:0]  nonce_end;
  logic [DIGEST_W-1:0] target;
  logic [MSG_W-1:0]    sha_msg;
  logic                sha_begin;
  logic                sha_complete;
  logic [DIGEST_W-1:0] sha_digest;
  logic                busy;
  logic                done;
  logic                found;
  logic                exhausted;
  logic                aborted;
  logic                error;
  logic [NONCE_W-1:0]  found_nonce;
  logic [DIGEST_W-1:0] found_digest;
  logic [31:0]         hash_count;

  modport slave (
    input  start, abort, header_prefix, nonce_start, nonce_end, target,
           sha_complete, sha_digest,
    output sha_msg, sha_begin, busy, done, found, exhausted, aborted, error,
           found_nonce, found_digest, hash_count
  );

  modport master (
    output start, abort, header_prefix, nonce_start, nonce_end, target,
           sha_complete, sha_digest,
    input  sha_msg, sha_begin, busy, done, found, exhausted, aborted, error,
           found_nonce, found_digest, hash_count
  );
endinterface

// File: rtl/sha_nonce_scheduler.sv
// Steps a nonce through a range, hashing {header, nonce} until the digest
// beats the target, the range ends, the search is aborted or SHA times out.
module sha_nonce_scheduler
  import miner_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  sha_nonce_scheduler_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [HEADER_W-1:0] header_q, header_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d, nonce_end_q, nonce_end_d;
  logic [DIGEST_W-1:0] target_q, target_d, fdigest_q, fdigest_d;
  logic [NONCE_W-1:0]  fnonce_q, fnonce_d;
  logic [31:0]         hcnt_q, hcnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                found_q, found_d, exh_q, exh_d, abrt_q, abrt_d, err_q, err_d;
  logic                timeout;

  // tmo_q equals cycles elapsed since sha_begin; deciding one cycle early
  // lands done exactly TIMEOUT_CYCLES after the begin pulse.
  assign timeout = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    nonce_d     = nonce_q;
    nonce_end_d = nonce_end_q;
    target_d    = target_q;
    fnonce_d    = fnonce_q;
    fdigest_d   = fdigest_q;
    hcnt_d      = hcnt_q;
    tmo_d       = tmo_q;
    found_d     = found_q;
    exh_d       = exh_q;
    abrt_d      = abrt_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        header_d    = bus.header_prefix;
        nonce_d     = bus.nonce_start;
        nonce_end_d = bus.nonce_end;
        target_d    = bus.target;
        hcnt_d      = '0;
        found_d     = 1'b0;
        abrt_d      = 1'b0;
        err_d       = 1'b0;
        exh_d       = (bus.nonce_end < bus.nonce_start);
        state_d     = (bus.nonce_end < bus.nonce_start) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        tmo_d   = TW'(1);
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else if (!bus.sha_complete) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else if (bus.sha_complete) state_d = S_CHECK;
      end
      S_CHECK: begin
        hcnt_d  = hcnt_q + 32'd1;
        state_d = S_FINISH;
        if (bus.sha_digest < target_q) begin
          found_d   = 1'b1;
          fnonce_d  = nonce_q;
          fdigest_d = bus.sha_digest;
        end else if (bus.abort) begin
          abrt_d = 1'b1;
        end else if (nonce_q == nonce_end_q) begin
          // end test precedes the increment so an all-ones end never wraps
          exh_d = 1'b1;
        end else begin
          nonce_d = nonce_q + NONCE_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      header_q    <= '0;
      nonce_q     <= '0;
      nonce_end_q <= '0;
      target_q    <= '0;
      fnonce_q    <= '0;
      fdigest_q   <= '0;
      hcnt_q      <= '0;
      tmo_q       <= '0;
      found_q     <= 1'b0;
      exh_q       <= 1'b0;
      abrt_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      nonce_q     <= nonce_d;
      nonce_end_q <= nonce_end_d;
      target_q    <= target_d;
      fnonce_q    <= fnonce_d;
      fdigest_q   <= fdigest_d;
      hcnt_q      <= hcnt_d;
      tmo_q       <= tmo_d;
      found_q     <= found_d;
      exh_q       <= exh_d;
      abrt_q      <= abrt_d;
      err_q       <= err_d;
    end
  end

  assign bus.sha_msg      = {header_q, nonce_q};
  assign bus.sha_begin    = (state_q == S_ISSUE);
  assign bus.done         = (state_q == S_FINISH);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.found        = found_q;
  assign bus.exhausted    = exh_q;
  assign bus.aborted      = abrt_q;
  assign bus.error        = err_q;
  assign bus.found_nonce  = fnonce_q;
  assign bus.found_digest = fdigest_q;
  assign bus.hash_count   = hcnt_q;
endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench: SHA stub (latency 20, digest = 1000 - nonce) plus a
// scoreboard of expected search outcomes popped at each done pulse.
module tb_sha_nonce_scheduler;
  import miner_pkg::*;

  typedef struct {
    logic        f, x, a, e;
    logic [31:0] nonce;
    logic [255:0] dig;
    logic [31:0] cnt;
    int          begins;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha_nonce_scheduler_if bus();
  sha_nonce_scheduler #(.TIMEOUT_CYCLES(255)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0, begins = 0, dones = 0;
  int start_cyc = 0, first_begin_cyc = -1, done_cyc = -1;
  logic stub_dis = 1'b0, watch_wrap = 1'b0, wrap_bad = 1'b0;
  logic [5:0] lat;
  exp_t sb[$];
  logic [HEADER_W-1:0] hdr;

  always @(posedge clk) cyc <= cyc + 1;

  // SHA stub: complete drops on begin, rises 20 cycles later, holds until next begin
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sha_complete <= 1'b0;
      bus.sha_digest   <= '0;
      lat              <= '0;
    end else if (bus.sha_begin) begin
      bus.sha_complete <= 1'b0;
      bus.sha_digest   <= 256'(1000) - 256'(bus.sha_msg[31:0]);
      lat              <= stub_dis ? 6'd0 : 6'd20;
    end else if (lat != 6'd0) begin
      lat <= lat - 6'd1;
      if (lat == 6'd1) bus.sha_complete <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.sha_begin) begin
      if (begins == 0) first_begin_cyc = cyc;
      begins++;
    end
    if (bus.done) begin
      dones++;
      done_cyc = cyc;
    end
    if (watch_wrap && bus.busy && bus.sha_msg[31:0] == 32'd0) wrap_bad = 1'b1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] ns, ne, input logic [255:0] tgt);
    exp_t r;
    logic [255:0] d;
    r.f = 0; r.x = 0; r.a = 0; r.e = 0; r.nonce = 0; r.dig = 0; r.cnt = 0; r.begins = 0;
    if (ne < ns) begin
      r.x = 1;
      return r;
    end
    for (longint n = longint'(ns); n <= longint'(ne); n++) begin
      r.cnt++;
      r.begins++;
      d = 256'(1000) - 256'(n[31:0]);
      if (d < tgt) begin
        r.f = 1; r.nonce = n[31:0]; r.dig = d;
        return r;
      end
    end
    r.x = 1;
    return r;
  endfunction

  task automatic launch(input logic [31:0] ns, ne, input logic [255:0] tgt);
    tick();
    bus.nonce_start   = ns;
    bus.nonce_end     = ne;
    bus.target        = tgt;
    bus.header_prefix = hdr;
    bus.start         = 1'b1;
    start_cyc         = cyc;
    begins            = 0;
    dones             = 0;
    first_begin_cyc   = -1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic finish_check(input string tag);
    int n = 0;
    exp_t e;
    while (dones == 0 && n < 600) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 256'(dones != 0), 256'(1));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 256'(0), 256'(1));
      return;
    end
    e = sb.pop_front();
    chk({tag, "_found"}, 256'(bus.found), 256'(e.f));
    chk({tag, "_exhausted"}, 256'(bus.exhausted), 256'(e.x));
    chk({tag, "_aborted"}, 256'(bus.aborted), 256'(e.a));
    chk({tag, "_error"}, 256'(bus.error), 256'(e.e));
    chk({tag, "_hash_count"}, 256'(bus.hash_count), 256'(e.cnt));
    if (e.f) begin
      chk({tag, "_found_nonce"}, 256'(bus.found_nonce), 256'(e.nonce));
      chk({tag, "_found_digest"}, bus.found_digest, e.dig);
    end
    tick();
    tick();
    chk({tag, "_done_pulses"}, 256'(dones), 256'(1));
    chk({tag, "_begins"}, 256'(begins), 256'(e.begins));
    chk({tag, "_busy_after"}, 256'(bus.busy), 256'(0));
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
    chk({tag, "_done"}, 256'(bus.done), 256'(0));
    chk({tag, "_begin"}, 256'(bus.sha_begin), 256'(0));
    chk({tag, "_status"}, 256'({bus.found, bus.exhausted, bus.aborted, bus.error}), 256'(0));
    chk({tag, "_msg_nonzero"}, 256'(|bus.sha_msg), 256'(0));
    chk({tag, "_hash_count"}, 256'(bus.hash_count), 256'(0));
    chk({tag, "_found_nonce"}, 256'(bus.found_nonce), 256'(0));
    chk({tag, "_found_digest"}, bus.found_digest, 256'(0));
  endtask

  initial begin
    exp_t e;
    int n;
    hdr               = {51{8'hA5}};
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.header_prefix = '0;
    bus.nonce_start   = '0;
    bus.nonce_end     = '0;
    bus.target        = '0;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    sb.push_back(model(32'd0, 32'd20, 256'd995));
    launch(32'd0, 32'd20, 256'd995);
    chk("found_begin_latency", 256'(first_begin_cyc - start_cyc), 256'(1));
    finish_check("found");

    sb.push_back(model(32'd5, 32'd7, 256'd0));
    launch(32'd5, 32'd7, 256'd0);
    finish_check("exh");

    watch_wrap = 1'b1;
    wrap_bad   = 1'b0;
    sb.push_back(model(32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'd0));
    launch(32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'd0);
    finish_check("wrap");
    watch_wrap = 1'b0;
    chk("wrap_nonce_zero_seen", 256'(wrap_bad), 256'(0));
    chk("wrap_header", 256'(|(bus.sha_msg[MSG_W-1:NONCE_W] ^ hdr)), 256'(0));
    chk("wrap_last_nonce", 256'(bus.sha_msg[31:0]), 256'(32'hFFFF_FFFF));

    sb.push_back(model(32'd10, 32'd9, 256'd0));
    launch(32'd10, 32'd9, 256'd0);
    chk("empty_done_latency", 256'(done_cyc - start_cyc), 256'(1));
    finish_check("empty");

    stub_dis = 1'b1;
    e = model(32'd0, 32'd0, 256'd0);
    e.x = 0; e.e = 1; e.cnt = 0; e.begins = 1;
    sb.push_back(e);
    launch(32'd0, 32'd20, 256'd0);
    finish_check("timeout");
    chk("timeout_latency", 256'(done_cyc - first_begin_cyc), 256'(255));
    stub_dis = 1'b0;

    e = model(32'd0, 32'd3, 256'd0);
    e.x = 0; e.a = 1;
    sb.push_back(e);
    launch(32'd0, 32'd20, 256'd0);
    n = 0;
    while (begins < 4 && n < 400) begin
      tick();
      n++;
    end
    chk("abort_reach_nonce3", 256'(begins >= 4), 256'(1));
    repeat (10) tick();
    bus.abort = 1'b1;
    finish_check("abort");
    bus.abort = 1'b0;

    launch(32'd0, 32'd20, 256'd0);
    n = 0;
    while (begins < 2 && n < 200) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk("rst_mid_busy_before", 256'(bus.busy), 256'(1));
    rst = 1'b1;
    tick();
    check_idle_zero("rst_mid");
    dones = 0;
    tick();
    rst = 1'b0;
    chk("rst_mid_no_done", 256'(dones), 256'(0));

    sb.push_back(model(32'd5, 32'd7, 256'd0));
    launch(32'd5, 32'd7, 256'd0);
    finish_check("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha_nonce_scheduler.md
# sha_nonce_scheduler

Sequencing controller that drives the single-block SHA computational datapath for nonce search. It forms each 440-bit message from a fixed 408-bit header prefix plus a 32-bit nonce, then starts the SHA block and waits for completion. It compares each digest against a target and either reports the winning nonce or steps to the next one until the range is exhausted, aborted or timed out. It sits between the miner top-level control and the SHA computational block.

## Interface
- TIMEOUT_CYCLES, 255, max cycles from sha_begin to sha_complete before error
- NONCE_W, 32, nonce width; header prefix width = 440 - NONCE_W
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a search; sampled only in IDLE
- abort  in  1  level; stop search after the in-flight hash
- header_prefix  in  408  message bits [439:32]; captured on accepted start
- nonce_start  in  32  first nonce, inclusive; captured on accepted start
- nonce_end  in  32  last nonce, inclusive; captured on accepted start
- target  in  256  digest found when digest < target, unsigned; captured on accepted start
- sha_msg  out  440  {header_q, nonce_q} to SHA inputMsg
- sha_begin  out  1  one-cycle start pulse to SHA beginComputation
- sha_complete  in  1  SHA computationComplete, level
- sha_digest  in  256  SHA output, valid while sha_complete high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a search ends, for any reason
- found, exhausted, aborted, error  out  1 each  end status; exactly one set per search, held until next accepted start
- found_nonce  out  32  winning nonce, valid with found
- found_digest  out  256  winning digest, valid with found
- hash_count  out  32  digests checked in current or last search

## Operation
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, CHECK, FINISH.
- IDLE: start=1 captures inputs, clears status and hash_count, and sets nonce_q=nonce_start. If nonce_end < nonce_start, go to FINISH with exhausted and issue no hash. Otherwise go to ISSUE.
- ISSUE: sha_begin=1 for this cycle only, clear the timeout counter, and go to WAIT_LOW.
- WAIT_LOW: wait for sha_complete=0, which absorbs a completion flag left high by the previous hash. Then go to WAIT_HIGH.
- WAIT_HIGH: wait for sha_complete=1, then go to CHECK.
- The timeout counter counts every cycle spent in WAIT_LOW or WAIT_HIGH. When it reaches TIMEOUT_CYCLES, set error and go to FINISH. Timeout takes priority over a same-cycle sha_complete.
- CHECK: increment hash_count, then take the first matching branch in this order:
  - sha_digest < target: set found, latch found_nonce=nonce_q and found_digest.
  - else abort=1: set aborted.
  - else nonce_q == nonce_end: set exhausted.
  - else nonce_q+1 and go to ISSUE.
  - found, aborted and exhausted each go to FINISH.
- The end-of-range comparison happens before the increment, so nonce_end=FFFFFFFF never wraps to 0.
- FINISH: done=1 for one cycle, then go to IDLE.
- start is ignored while busy. abort is ignored in IDLE, ISSUE and FINISH, and sampled only in CHECK; an in-flight hash always completes.
- sha_msg holds constant from ISSUE until the next ISSUE or the next accepted start.
- Reset: state IDLE, and every output and register is 0, including sha_msg, found_nonce, found_digest and hash_count.

## Timing
- Accepted start at cycle t puts sha_begin at t+1, or done at t+1 for an empty range.
- Per nonce: ISSUE 1 cycle, WAIT_LOW ≥1, WAIT_HIGH until completion, CHECK 1 cycle.
- Next sha_begin comes 1 cycle after CHECK. done comes 1 cycle after the terminating CHECK or the timeout cycle.
- Status outputs update in the cycle done is high.
- Reset asserted mid-search returns the block to IDLE immediately, with no done pulse.

## Structure
- Put the following in a shared miner_pkg: state enum, MSG_W=440, DIGEST_W=256, NONCE_W, HEADER_W=408.
- No sub-module. The 256-bit comparator, nonce counter and timeout counter are inline.

## Test plan
All scenarios use a bench SHA stub with latency 20 cycles, digest = 1000 − nonce, and complete held high until the next begin.
- Range 0..20, target 995 -> found at nonce 6, found_digest=994, hash_count=7, one done pulse.
- Range 5..7, target 0 -> exhausted, hash_count=3, exactly 3 sha_begin pulses.
- Range FFFFFFFE..FFFFFFFF, target 0 -> exhausted after 2 hashes; sha_msg LSBs never show 0.
- Range 10..9 -> done one cycle after start, exhausted, no sha_begin.
- Stub never completes -> error and done exactly TIMEOUT_CYCLES=255 cycles after sha_begin.
- abort raised mid-WAIT_HIGH on nonce 3 of 0..20, target 0 -> aborted after that hash, hash_count=4.
- Reset during WAIT_HIGH -> all outputs 0 and IDLE; a new start then proceeds normally.
- Real SHA block substituted for the stub, header 0, nonce range 0x68656c6c..0x68656c6c, target all-ones -> found. The recorded digest equals the reference model's output for that 440-bit message.
